// File: rtl/code84n21_pkg.sv
// Shared types and constants for the 84-2-1 code to BCD sequencer.
package code84n21_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  // Codes 0001, 0010, 0011, 1100, 1101, 1110 have no decimal meaning.
  localparam logic [15:0] INVALID_MASK = 16'b0111_0000_0000_1110;

endpackage

// File: rtl/code84n21_digit_conv.sv
// Combinational 84-2-1 digit to BCD nibble converter.
module code84n21_digit_conv
  import code84n21_pkg::*;
(
  input  logic [3:0] code,
  output logic [3:0] bcd,
  output logic       invalid
);

  assign invalid = INVALID_MASK[code];

  always_comb begin
    bcd = 4'h0;
    unique case (code)
      4'h0:    bcd = 4'd0;
      4'h7:    bcd = 4'd1;
      4'h6:    bcd = 4'd2;
      4'h5:    bcd = 4'd3;
      4'h4:    bcd = 4'd4;
      4'hB:    bcd = 4'd5;
      4'hA:    bcd = 4'd6;
      4'h9:    bcd = 4'd7;
      4'h8:    bcd = 4'd8;
      4'hF:    bcd = 4'd9;
      default: bcd = 4'd0;
    endcase
  end

endmodule

// File: rtl/code84n21_bcd_sequencer.sv
// Word-wide 84-2-1 to BCD converter, one digit per clock,
// least-significant digit first, valid/ready on both sides.
module code84n21_bcd_sequencer
  import code84n21_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] out_bcd,
  output logic [NDIG-1:0]   out_err_mask,
  output logic              out_err
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

  state_t            state;
  logic [IW-1:0]     idx;
  logic [4*NDIG-1:0] cap;
  logic [3:0]        cur_code;
  logic [3:0]        cur_bcd;
  logic              cur_inv;

  // One shared converter; the captured word is muxed by idx.
  assign cur_code = cap[{idx, 2'b00} +: 4];

  code84n21_digit_conv u_conv (
    .code    (cur_code),
    .bcd     (cur_bcd),
    .invalid (cur_inv)
  );

  assign out_err = |out_err_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_bcd      <= '0;
      out_err_mask <= '0;
      idx          <= '0;
      cap          <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            cap          <= in_word;
            out_bcd      <= '0;
            out_err_mask <= '0;
            idx          <= '0;
            in_ready     <= 1'b0;
            state        <= CONV;
          end
        end
        CONV: begin
          out_bcd[{idx, 2'b00} +: 4] <= cur_bcd;
          out_err_mask[idx]          <= cur_inv;
          if (idx == LAST) begin
            idx       <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_code84n21_bcd_sequencer.sv
// Scoreboard bench: stimulus pushes expected results,
// a monitor pops and compares on each output handshake.
module tb_code84n21_bcd_sequencer;

  localparam int NDIG = 4;

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  mask;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_bcd;
  logic [3:0]  out_err_mask;
  logic        out_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_n = 0;
  int acc_cyc[$];
  exp_t sb[$];

  code84n21_bcd_sequencer #(.NDIG(NDIG)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_word      (in_word),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_bcd      (out_bcd),
    .out_err_mask (out_err_mask),
    .out_err      (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && in_valid && in_ready) begin
      acc_n++;
      acc_cyc.push_back(cyc);
    end
  end

  // Monitor: compare on every output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 32'(out_bcd), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_bcd", 32'(out_bcd), 32'(e.bcd));
        chk("out_err_mask", 32'(out_err_mask), 32'(e.mask));
        chk("out_err", 32'(out_err), 32'(|e.mask));
      end
    end
  end

  task automatic do_word(input logic [15:0] w, input logic [15:0] eb,
                         input logic [3:0] em, input logic chk_lat);
    int n0;
    int lat;
    sb.push_back('{bcd: eb, mask: em});
    n0 = acc_n;
    in_word = w;
    in_valid = 1'b1;
    for (int i = 0; i < 30 && acc_n == n0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("accept", 32'(acc_n), 32'(n0 + 1));
    in_valid = 1'b0;
    in_word = ~w;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("valid_seen", 32'(out_valid), 32'd1);
    if (chk_lat) chk("latency", 32'(lat), 32'(NDIG));
    if (out_ready) begin
      @(posedge clk);
      #1;
      chk("valid_drop", 32'(out_valid), 32'd0);
      chk("in_ready_back", 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    logic [3:0]  tab [16];
    logic [15:0] inv;
    int n0;
    int t1;
    tab = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h3, 4'h2, 4'h1,
            4'h8, 4'h7, 4'h6, 4'h5, 4'h0, 4'h0, 4'h0, 4'h9};
    inv = 16'b0111_0000_0000_1110;

    rst = 1'b1;
    in_valid = 1'b0;
    in_word = 16'h0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_bcd", 32'(out_bcd), 32'd0);
    chk("rst_out_err", 32'({out_err_mask, out_err}), 32'd0);

    do_word(16'hF897, 16'h9871, 4'b0000, 1'b1);
    do_word(16'h0C00, 16'h0000, 4'b0100, 1'b1);

    for (int n = 0; n < 16; n++)
      do_word(16'(n), {12'h0, tab[n]}, {3'b000, inv[n]}, 1'b0);

    // Backpressure with in_valid high and in_word changing.
    out_ready = 1'b0;
    do_word(16'h0C00, 16'h0000, 4'b0100, 1'b0);
    n0 = acc_n;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_word = 16'h1234 + 16'(k * 16'h1111);
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_bcd", 32'(out_bcd), 32'h0000);
      chk("bp_mask", 32'(out_err_mask), 32'h4);
      @(posedge clk);
      #1;
    end
    chk("bp_no_capture", 32'(acc_n), 32'(n0));
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release", 32'(out_valid), 32'd0);

    // Reset on the second CONV cycle.
    n0 = acc_n;
    in_word = 16'hF897;
    in_valid = 1'b1;
    for (int i = 0; i < 30 && acc_n == n0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("rst_mid_accept", 32'(acc_n), 32'(n0 + 1));
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_bcd", 32'(out_bcd), 32'd0);
    chk("rst_mid_mask", 32'(out_err_mask), 32'd0);
    do_word(16'h0007, 16'h0001, 4'b0000, 1'b1);

    // Back-to-back with in_valid held high.
    sb.push_back('{bcd: 16'h4321, mask: 4'b0000});
    sb.push_back('{bcd: 16'h6565, mask: 4'b0000});
    n0 = acc_n;
    in_word = 16'h4567;
    in_valid = 1'b1;
    for (int i = 0; i < 30 && acc_n == n0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("b2b_accept1", 32'(acc_n), 32'(n0 + 1));
    t1 = acc_cyc[acc_cyc.size() - 1];
    in_word = 16'hABAB;
    for (int i = 0; i < 30 && acc_n == n0 + 1; i++) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("b2b_accept2", 32'(acc_n), 32'(n0 + 2));
    chk("b2b_gap", 32'(acc_cyc[acc_cyc.size() - 1] - t1), 32'd6);

    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
